// File: rtl/spi_coeff_writer_if.sv
// spi_coeff_writer_if: coefficient stream, frame control and SPI pins of the coefficient writer
interface spi_coeff_writer_if #(
    parameter int DataWidth = 8
);
    logic                 start;
    logic [DataWidth-1:0] coeffData;
    logic                 coeffValid;
    logic                 coeffReady;
    logic                 spiClk;
    logic                 mosi;
    logic                 cs;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, coeffData, coeffValid,
        output coeffReady, spiClk, mosi, cs, busy, done
    );

    modport slave (
        output start, coeffData, coeffValid,
        input  coeffReady, spiClk, mosi, cs, busy, done
    );
endinterface

// File: rtl/spi_coeff_writer.sv
// spi_coeff_writer: streams one coefficient set MSB-first over SPI mode 0 inside a single cs-low frame
module spi_coeff_writer #(
    parameter int NTaps     = 11,
    parameter int DataWidth = 8,
    parameter int ClkDiv    = 4
) (
    input  logic             clk,
    input  logic             resetN,
    spi_coeff_writer_if.master bus
);
    localparam int CW   = $clog2(NTaps + 1);
    localparam int BW   = $clog2(DataWidth);
    localparam int DivW = $clog2(ClkDiv);

    typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, HOLD} state_t;

    state_t               state_q, state_d;
    logic [DataWidth-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DataWidth-2:0] shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [CW-1:0]        word_q, word_d;
    logic [CW-1:0]        acc_q, acc_d;
    logic [DivW-1:0]      div_q, div_d;
    logic                 spi_q, spi_d;
    logic                 mosi_q, mosi_d;
    logic                 cs_q, cs_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ready, div_last;

    assign ready      = !hold_full_q && (acc_q < CW'(NTaps));
    assign div_last   = div_q == DivW'(ClkDiv - 1);
    assign bus.coeffReady = ready;
    assign bus.spiClk = spi_q;
    assign bus.mosi   = mosi_q;
    assign bus.cs     = cs_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

    // Register update; reset abandons any partial frame and empties the hold register
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_q       <= '0;
            word_q      <= '0;
            acc_q       <= '0;
            div_q       <= '0;
            spi_q       <= 1'b0;
            mosi_q      <= 1'b0;
            cs_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            word_q      <= word_d;
            acc_q       <= acc_d;
            div_q       <= div_d;
            spi_q       <= spi_d;
            mosi_q      <= mosi_d;
            cs_q        <= cs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Hold-register fill from the stream, and the frame sequencer driving the SPI pins
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        word_d      = word_q;
        acc_d       = acc_q;
        div_d       = div_q;
        spi_d       = spi_q;
        mosi_d      = mosi_q;
        cs_d        = cs_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        if (bus.coeffValid && ready) begin
            hold_d      = bus.coeffData;
            hold_full_d = 1'b1;
            acc_d       = acc_q + CW'(1);
        end
        case (state_q)
            LOAD: begin
                if (hold_full_q) begin
                    shift_d     = hold_q[DataWidth-2:0];
                    mosi_d      = hold_q[DataWidth-1];
                    hold_full_d = 1'b0;
                    bit_d       = '0;
                    div_d       = '0;
                    state_d     = LOW;
                end
            end
            LOW: begin
                div_d = div_last ? '0 : div_q + DivW'(1);
                spi_d = div_last;
                state_d = div_last ? HIGH : LOW;
            end
            HIGH: begin
                div_d = div_last ? '0 : div_q + DivW'(1);
                spi_d = !div_last;
                if (div_last) begin
                    if (bit_q != BW'(DataWidth - 1)) begin
                        bit_d   = bit_q + BW'(1);
                        mosi_d  = shift_q[DataWidth-2];
                        shift_d = shift_q << 1;
                        state_d = LOW;
                    end else if (word_q != CW'(NTaps - 1)) begin
                        word_d  = word_q + CW'(1);
                        state_d = LOAD;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                div_d = div_last ? '0 : div_q + DivW'(1);
                if (div_last) begin
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                    acc_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                if (bus.start) begin
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    word_d  = '0;
                    state_d = LOAD;
                end
            end
        endcase
    end
endmodule
